// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: NxN output-stationary systolic matrix multiplier with input skew, handshakes, flush and row drain
module systolic_mm_engine #(
    parameter int N      = 4,
    parameter int DW     = 16,
    parameter int ACCW   = 2*DW+$clog2(N),
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*DW-1:0]      a_col,
    input  logic [N*DW-1:0]      b_row,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*ACCW-1:0]    out_row,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 busy,
    output logic                 done
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(2*N);
    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] idx_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;
    logic          done_q;
    logic          en;
    logic          clr;
    logic [DW-1:0]   a_w   [N][N];
    logic [DW-1:0]   b_w   [N][N];
    logic [ACCW-1:0] acc_w [N][N];

    // The array only steps on an accepted beat or during flush; start clears all accumulators
    assign en  = (state_q == LOAD && in_valid) || state_q == FLUSH;
    assign clr = state_q == IDLE && start;

    // Control FSM: sequences load, flush, drain and done with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q    <= LOAD;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b1;
                end
                LOAD: if (in_valid) begin
                    if (cnt_q == CW'(N-1)) begin
                        state_q    <= FLUSH;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                FLUSH: if (cnt_q == CW'(2*N-3)) begin
                    state_q     <= DRAIN;
                    idx_q       <= '0;
                    out_valid_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                DRAIN: if (out_ready) begin
                    if (idx_q == IW'(N-1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    genvar i, j;
    generate
        for (i = 0; i < N; i++) begin : g_skew
            logic [DW-1:0] a_in;
            logic [DW-1:0] b_in;
            assign a_in = state_q == LOAD ? a_col[i*DW +: DW] : '0;
            assign b_in = state_q == LOAD ? b_row[i*DW +: DW] : '0;
            if (i == 0) begin : g_direct
                assign a_w[0][0] = a_in;
                assign b_w[0][0] = b_in;
            end else begin : g_delay
                logic [DW-1:0] a_sr_q [i];
                logic [DW-1:0] b_sr_q [i];
                // Depth-i delay line so row i of A and column i of B enter the array i steps late
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        for (int d = 0; d < i; d++) begin
                            a_sr_q[d] <= '0;
                            b_sr_q[d] <= '0;
                        end
                    end else if (en) begin
                        a_sr_q[0] <= a_in;
                        b_sr_q[0] <= b_in;
                        for (int d = 1; d < i; d++) begin
                            a_sr_q[d] <= a_sr_q[d-1];
                            b_sr_q[d] <= b_sr_q[d-1];
                        end
                    end
                end
                assign a_w[i][0] = a_sr_q[i-1];
                assign b_w[0][i] = b_sr_q[i-1];
            end
        end
        for (i = 0; i < N; i++) begin : g_row
            for (j = 0; j < N; j++) begin : g_pe
                logic [2*DW-1:0]        pu;
                logic signed [2*DW-1:0] ps;
                logic [ACCW-1:0]        prod;
                logic [ACCW-1:0]        acc_q;
                assign pu   = {{DW{1'b0}}, a_w[i][j]} * {{DW{1'b0}}, b_w[i][j]};
                assign ps   = $signed({{DW{a_w[i][j][DW-1]}}, a_w[i][j]}) * $signed({{DW{b_w[i][j][DW-1]}}, b_w[i][j]});
                assign prod = SIGNED ? {{(ACCW-2*DW){ps[2*DW-1]}}, ps} : {{(ACCW-2*DW){1'b0}}, pu};
                // Output-stationary accumulator: cleared at job start, wraps mod 2^ACCW on each enabled step
                always_ff @(posedge clk) begin
                    if (!rst || clr) acc_q <= '0;
                    else if (en) acc_q <= acc_q + prod;
                end
                assign acc_w[i][j] = acc_q;
                if (j < N-1) begin : g_east
                    logic [DW-1:0] a_q;
                    // Pass the A operand one PE east per step
                    always_ff @(posedge clk) begin
                        if (!rst) a_q <= '0;
                        else if (en) a_q <= a_w[i][j];
                    end
                    assign a_w[i][j+1] = a_q;
                end
                if (i < N-1) begin : g_south
                    logic [DW-1:0] b_q;
                    // Pass the B operand one PE south per step
                    always_ff @(posedge clk) begin
                        if (!rst) b_q <= '0;
                        else if (en) b_q <= b_w[i][j];
                    end
                    assign b_w[i+1][j] = b_q;
                end
            end
        end
    endgenerate

    // Offer the accumulator row selected by the drain index; zero when no row is offered
    always_comb begin
        out_row = '0;
        for (int c = 0; c < N; c++) out_row[c*ACCW +: ACCW] = out_valid_q ? acc_w[idx_q][c] : '0;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine: randomized self-checking bench for systolic_mm_engine against a plain matrix-product model
module tb_systolic_mm_engine;
    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int ACCW = 2*DW + $clog2(N);
    localparam int IW   = $clog2(N);
    localparam int D8   = 8;
    localparam int A8W  = 2*D8 + $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [N*DW-1:0] a_col = '0;
    logic [N*DW-1:0] b_row = '0;
    logic in_ready, out_valid, busy, done;
    logic [N*ACCW-1:0] out_row;
    logic [IW-1:0] out_idx;

    logic start8 = 1'b0;
    logic in_valid8 = 1'b0;
    logic out_ready8 = 1'b1;
    logic [N*D8-1:0] a8 = '0;
    logic [N*D8-1:0] b8 = '0;
    logic s_in_ready, s_out_valid, s_busy, s_done;
    logic u_in_ready, u_out_valid, u_busy, u_done;
    logic [N*A8W-1:0] s_out_row, u_out_row;
    logic [IW-1:0] s_out_idx, u_out_idx;

    always #5 clk = ~clk;

    systolic_mm_engine #(.N(N), .DW(DW), .SIGNED(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_idx(out_idx), .busy(busy), .done(done));

    systolic_mm_engine #(.N(N), .DW(D8), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start8), .in_valid(in_valid8), .in_ready(s_in_ready),
        .a_col(a8), .b_row(b8), .out_valid(s_out_valid), .out_ready(out_ready8),
        .out_row(s_out_row), .out_idx(s_out_idx), .busy(s_busy), .done(s_done));

    systolic_mm_engine #(.N(N), .DW(D8), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(start8), .in_valid(in_valid8), .in_ready(u_in_ready),
        .a_col(a8), .b_row(b8), .out_valid(u_out_valid), .out_ready(out_ready8),
        .out_row(u_out_row), .out_idx(u_out_idx), .busy(u_busy), .done(u_done));

    longint A [N][N];
    longint B [N][N];
    logic [N*ACCW-1:0] got [N];
    logic [IW-1:0] got_idx [N];
    int rows, first_valid, done_cyc, rows_at_done, stall_err, rdy_cycles, tmo;
    int S8A [N][N];
    int S8B [N][N];
    logic [N*A8W-1:0] s_got [N];
    logic [N*A8W-1:0] u_got [N];
    int checks = 0;
    int errors = 0;

    // Reference: row i of C = A x B, reduced mod 2^ACCW
    function automatic logic [N*ACCW-1:0] exp_row(int i);
        logic [N*ACCW-1:0] r;
        longint s;
        r = '0;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += A[i][k] * B[k][j];
            r[j*ACCW +: ACCW] = ACCW'(s);
        end
        return r;
    endfunction

    task automatic set_t1();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                A[i][k] = 4*i + k;
                B[i][k] = (i == k) ? 1 : 0;
            end
    endtask

    task automatic set_rand();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                A[i][k] = $urandom_range(65535);
                B[i][k] = $urandom_range(65535);
            end
    endtask

    // Drive one job on the main DUT and record rows and timing; vmode 0 steady/1 gap/2 random, rmode 0 steady/1 1-0-0/2 random
    task automatic run_job(input int vmode, input int rmode, input int xstart, input int abort);
        int k, c, fin, gap, rc, pv, pr;
        logic v;
        logic [N*ACCW-1:0] prow;
        logic [IW-1:0] pidx;
        k = 0; fin = 0; gap = 0; rc = 0; pv = 0; pr = 0; prow = '0; pidx = '0;
        rows = 0; first_valid = -1; done_cyc = -1; rows_at_done = -1; stall_err = 0; rdy_cycles = 0; tmo = 0;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        for (c = 1; fin == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c > 200) begin tmo = 1; fin = 1; end
            if (in_ready) rdy_cycles++;
            if (out_valid && first_valid < 0) first_valid = c;
            if (pv && !pr && out_valid && (out_row !== prow || out_idx !== pidx)) stall_err++;
            if (done) begin
                done_cyc = c; rows_at_done = rows; fin = 1;
                if (xstart != 0) start = 1'b1;
            end
            if (xstart != 0 && in_ready && k == 1) start = 1'b1;
            if (xstart != 0 && out_valid && rows == 1) start = 1'b1;
            if (abort != 0 && c == N + 3) begin rst = 1'b0; fin = 1; end
            for (int i = 0; i < N; i++) begin
                a_col[i*DW +: DW] = DW'($urandom);
                b_row[i*DW +: DW] = DW'($urandom);
            end
            in_valid = 1'b0;
            if (in_ready && k < N) begin
                v = (vmode == 0) || (vmode == 1 && (k != 2 || gap == 3)) || (vmode == 2 && $urandom_range(2) != 0);
                if (vmode == 1 && k == 2 && gap < 3) gap++;
                if (v) begin
                    for (int i = 0; i < N; i++) begin
                        a_col[i*DW +: DW] = DW'(A[i][k]);
                        b_row[i*DW +: DW] = DW'(B[k][i]);
                    end
                    in_valid = 1'b1;
                    k++;
                end
            end
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (rc % 3 == 0) : 1'($urandom_range(1));
            if (out_valid) begin
                rc++;
                if (out_ready) begin
                    if (rows < N) begin got[rows] = out_row; got_idx[rows] = out_idx; end
                    rows++;
                end
            end
            pv = out_valid; pr = out_ready; prow = out_row; pidx = out_idx;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    // Drive one job on both 8-bit DUTs in lockstep with steady valid/ready
    task automatic run_job8(output int ok);
        int k, r, c;
        k = 0; r = 0; c = 0;
        @(negedge clk);
        start8 = 1'b1;
        while (r < N && c < 100) begin
            @(negedge clk);
            start8 = 1'b0;
            c++;
            in_valid8 = 1'b0;
            if (s_in_ready && k < N) begin
                for (int i = 0; i < N; i++) begin
                    a8[i*D8 +: D8] = D8'(S8A[i][k]);
                    b8[i*D8 +: D8] = D8'(S8B[k][i]);
                end
                in_valid8 = 1'b1;
                k++;
            end
            if (s_out_valid) begin s_got[r] = s_out_row; u_got[r] = u_out_row; r++; end
        end
        in_valid8 = 1'b0;
        ok = (r == N) ? 1 : 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy, done} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0000", {in_ready, out_valid, busy, done});
        end
        checks++;
        if (out_row !== '0 || out_idx !== '0) begin
            errors++; $display("FAIL reset_data got row %h idx %0d exp 0", out_row, out_idx);
        end
        checks++;
        if ({s_busy, u_busy, s_out_valid, u_out_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_8bit got %b exp 0000", {s_busy, u_busy, s_out_valid, u_out_valid});
        end
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL idle_hold got busy %b in_ready %b exp 0 0", busy, in_ready);
        end
    endtask

    task automatic test_identity();
        set_t1();
        run_job(0, 0, 0, 0);
        checks++;
        if (tmo != 0 || first_valid != 3*N-1) begin
            errors++; $display("FAIL t1_first_valid got %0d exp %0d (tmo %0d)", first_valid, 3*N-1, tmo);
        end
        checks++;
        if (done_cyc != 4*N-1 || rows_at_done != N) begin
            errors++; $display("FAIL t1_done got cycle %0d rows %0d exp %0d %0d", done_cyc, rows_at_done, 4*N-1, N);
        end
        checks++;
        if (rdy_cycles != N) begin
            errors++; $display("FAIL t1_in_ready got %0d exp %0d", rdy_cycles, N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got_idx[i] !== IW'(i) || got[i] !== exp_row(i)) begin
                errors++; $display("FAIL t1_row%0d got idx %0d row %h exp idx %0d row %h", i, got_idx[i], got[i], i, exp_row(i));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL t1_after_done got done %b busy %b exp 0 0", done, busy);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                A[i][k] = i + 1;
                B[i][k] = k + 1;
            end
        run_job(1, 0, 0, 0);
        checks++;
        if (tmo != 0 || rdy_cycles != N + 3 || first_valid != 3*N+2) begin
            errors++; $display("FAIL t2_gap_timing got ready %0d first %0d exp %0d %0d", rdy_cycles, first_valid, N+3, 3*N+2);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] !== exp_row(i)) begin
                errors++; $display("FAIL t2_row%0d got %h exp %h", i, got[i], exp_row(i));
            end
        end
        set_rand();
        run_job(2, 0, 0, 0);
        checks++;
        if (tmo != 0 || rows_at_done != N) begin
            errors++; $display("FAIL t2_rand_rows got %0d exp %0d", rows_at_done, N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] !== exp_row(i)) begin
                errors++; $display("FAIL t2_rand_row%0d got %h exp %h", i, got[i], exp_row(i));
            end
        end
    endtask

    task automatic test_backpressure();
        set_t1();
        run_job(0, 1, 0, 0);
        checks++;
        if (tmo != 0 || stall_err != 0) begin
            errors++; $display("FAIL t3_stable got %0d changes exp 0", stall_err);
        end
        checks++;
        if (rows_at_done != N || done_cyc != 3*N-1 + 3*(N-1) + 1) begin
            errors++; $display("FAIL t3_done got rows %0d cycle %0d exp %0d %0d", rows_at_done, done_cyc, N, 3*N-1 + 3*(N-1) + 1);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got_idx[i] !== IW'(i) || got[i] !== exp_row(i)) begin
                errors++; $display("FAIL t3_row%0d got idx %0d row %h exp %h", i, got_idx[i], got[i], exp_row(i));
            end
        end
    endtask

    task automatic test_signed();
        int ok;
        logic [N*A8W-1:0] es, eu;
        int ss, su;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < N; i++)
                for (int k = 0; k < N; k++) begin
                    S8A[i][k] = (pass == 0) ? -1 : $urandom_range(255) - 128;
                    S8B[i][k] = (pass == 0) ? -128 : $urandom_range(255) - 128;
                end
            run_job8(ok);
            checks++;
            if (ok != 1) begin
                errors++; $display("FAIL t4_rows pass %0d got incomplete exp %0d rows", pass, N);
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    ss = 0; su = 0;
                    for (int k = 0; k < N; k++) begin
                        ss += S8A[i][k] * S8B[k][j];
                        su += (S8A[i][k] & 255) * (S8B[k][j] & 255);
                    end
                    es[j*A8W +: A8W] = A8W'(ss);
                    eu[j*A8W +: A8W] = A8W'(su);
                end
                checks++;
                if (s_got[i] !== es) begin
                    errors++; $display("FAIL t4_signed pass %0d row%0d got %h exp %h", pass, i, s_got[i], es);
                end
                checks++;
                if (u_got[i] !== eu) begin
                    errors++; $display("FAIL t4_unsigned pass %0d row%0d got %h exp %h", pass, i, u_got[i], eu);
                end
            end
        end
    endtask

    task automatic test_reset_flush();
        int nd;
        set_t1();
        run_job(0, 0, 0, 1);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy, done} !== 4'b0000 || out_row !== '0 || out_idx !== '0) begin
            errors++; $display("FAIL t5_reset got ctrl %b row %h idx %0d exp all 0", {in_ready, out_valid, busy, done}, out_row, out_idx);
        end
        rst = 1'b1;
        nd = 0;
        repeat (16) begin
            @(negedge clk);
            if (done) nd++;
        end
        checks++;
        if (nd != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL t5_no_done got %0d pulses busy %b exp 0 0", nd, busy);
        end
        run_job(0, 0, 0, 0);
        checks++;
        if (tmo != 0 || first_valid != 3*N-1 || done_cyc != 4*N-1) begin
            errors++; $display("FAIL t5_rerun_timing got %0d %0d exp %0d %0d", first_valid, done_cyc, 3*N-1, 4*N-1);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] !== exp_row(i)) begin
                errors++; $display("FAIL t5_row%0d got %h exp %h", i, got[i], exp_row(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        set_rand();
        run_job(0, 0, 1, 0);
        checks++;
        if (tmo != 0 || first_valid != 3*N-1 || done_cyc != 4*N-1) begin
            errors++; $display("FAIL t6_job1_timing got %0d %0d exp %0d %0d", first_valid, done_cyc, 3*N-1, 4*N-1);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] !== exp_row(i)) begin
                errors++; $display("FAIL t6_job1_row%0d got %h exp %h", i, got[i], exp_row(i));
            end
        end
        set_rand();
        run_job(0, 0, 0, 0);
        checks++;
        if (tmo != 0 || first_valid != 3*N-1 || done_cyc != 4*N-1) begin
            errors++; $display("FAIL t6_job2_timing got %0d %0d exp %0d %0d", first_valid, done_cyc, 3*N-1, 4*N-1);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] !== exp_row(i)) begin
                errors++; $display("FAIL t6_job2_row%0d got %h exp %h", i, got[i], exp_row(i));
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            set_rand();
            run_job(2, 2, 0, 0);
            checks++;
            if (tmo != 0 || stall_err != 0 || rows_at_done != N) begin
                errors++; $display("FAIL rand%0d_flow got tmo %0d changes %0d rows %0d exp 0 0 %0d", t, tmo, stall_err, rows_at_done, N);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (got_idx[i] !== IW'(i) || got[i] !== exp_row(i)) begin
                    errors++; $display("FAIL rand%0d_row%0d got %h exp %h", t, i, got[i], exp_row(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_stall();
        test_backpressure();
        test_signed();
        test_reset_flush();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
